key_debounce: RTL
=================

// Module: key_debounce
// PURPOSE
//   Conditions the raw active-low DE-series KEY pushbuttons before they reach
//   the display-address logic (load strobe, address reset) and any other
//   KEY consumer. Per key: 2-flop synchroniser, counter-based debounce,
//   one-cycle PRESS/RELEASE pulses and an optional hold-to-repeat pulse train.
//   KEY_LEVEL keeps the active-low polarity, so it replaces KEY 1:1 downstream.
// PARAMETERS
//   N_KEYS          4          number of independent keys
//   DEBOUNCE_CYCLES 1_000_000  cycles a new level must persist (20 ms @ 50 MHz); >=1
//   REPEAT_DELAY    25_000_000 cycles from PRESS to first REPEAT (500 ms); >=1
//   REPEAT_RATE     5_000_000  cycles between later REPEAT pulses (100 ms); >=1
// PORTS
//   CLOCK_50   in   1       system clock, all state on rising edge
//   Resetn     in   1       asynchronous active-low reset
//   KEY_IN     in   N_KEYS  raw pushbuttons, 0 = pressed, asynchronous
//   REPEAT_EN  in   1       1 = auto-repeat enabled for all keys
//   KEY_LEVEL  out  N_KEYS  debounced level, 0 = pressed
//   PRESS      out  N_KEYS  1-cycle pulse on debounced press
//   RELEASE    out  N_KEYS  1-cycle pulse on debounced release
//   REPEAT     out  N_KEYS  1-cycle pulse per repeat tick while held
// BEHAVIOUR
//   Reset: synchronisers and KEY_LEVEL = all 1s; PRESS/RELEASE/REPEAT = 0;
//     all counters 0; every key FSM in IDLE. All outputs registered.
//   Keys fully independent; any number may change on the same edge.
//   Synchroniser: s1 <= KEY_IN; s2 <= s1. Only s2 is used beyond this.
//   Debounce per key: s2==KEY_LEVEL -> cnt<=0; else if cnt==DEBOUNCE_CYCLES-1
//     -> KEY_LEVEL<=s2, cnt<=0; else cnt++. Any mismatch gap restarts count.
//   Latency: raw level held stable -> KEY_LEVEL changes on edge DEBOUNCE_CYCLES+2,
//     counting the first edge that samples the new raw value as edge 1.
//   PRESS high exactly the first cycle KEY_LEVEL reads 0; RELEASE exactly the
//     first cycle it reads 1 (set on the same edge as KEY_LEVEL).
//   Repeat FSM per key, rcnt sized $clog2(max(DELAY,RATE))+1:
//     IDLE : on debounced press -> HOLD, rcnt<=0.
//     HOLD : rcnt counts from the PRESS cycle; REPEAT pulse at PRESS cycle
//            +REPEAT_DELAY, then -> RPT, rcnt<=0.
//     RPT  : REPEAT pulse every REPEAT_RATE cycles after the previous pulse.
//     Any state: debounced release -> IDLE, rcnt<=0, RELEASE pulse.
//   REPEAT_EN=0: rcnt held at 0, no REPEAT; from RPT returns to HOLD.
//     On re-enable, first REPEAT comes REPEAT_DELAY cycles later.
//   Release and a due REPEAT on the same edge: release wins, REPEAT stays 0.
//   Reset mid-hold: on Resetn rise the key re-debounces from 1. A key still
//     held yields a fresh PRESS DEBOUNCE_CYCLES+2 edges later.
//   PRESS and REPEAT never assert in the same cycle (DELAY>=1).
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
//   1 Resetn=0, KEY_IN=4'b0000 -> KEY_LEVEL=4'b1111, pulses 0. Release reset
//     with KEY_IN[0]=0 held -> PRESS[0] on edge 6 after the release edge.
//   2 KEY_IN[1] 1->0 clean, held -> KEY_LEVEL[1]=0 and PRESS[1]=1 on edge 6,
//     PRESS[1] low next cycle. Then 1 clean -> RELEASE[1] on edge 6.
//   3 KEY_IN[2] toggles every 2 cycles for 40 cycles, then stays 1 ->
//     KEY_LEVEL[2] stays 1, no PRESS/RELEASE/REPEAT on bit 2.
//   4 REPEAT_EN=1, hold key 3 (PRESS at cycle t) -> REPEAT[3] at t+10, t+13,
//     t+16, ...; release -> RELEASE[3], no further REPEAT.
//   5 Release timed so debounced release falls on t+13 -> RELEASE only, no
//     REPEAT. With REPEAT_EN=0 held 30 cycles -> zero REPEAT pulses.
//   6 KEY_IN[0] and [3] pressed on the same edge -> PRESS=4'b1001 in one cycle.
//     Resetn pulse while both held -> both PRESS again 6 edges after reset.

Source files
------------

// File: rtl/key_debounce.sv
// Per-key conditioning of the active-low DE-series KEY pushbuttons: 2-flop synchroniser,
// counter debounce, one-cycle PRESS/RELEASE strobes and an optional hold-to-repeat pulse train.
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic [N_KEYS-1:0] KEY_IN,
  input  logic              REPEAT_EN,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] PRESS,
  output logic [N_KEYS-1:0] RELEASE,
  output logic [N_KEYS-1:0] REPEAT
);

  localparam int DCW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX) + 1;

  localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  logic [N_KEYS-1:0] sync1_r;
  logic [N_KEYS-1:0] sync2_r;

  // Two-flop synchroniser; idles at the released level (1) out of reset.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_r <= {N_KEYS{1'b1}};
      sync2_r <= {N_KEYS{1'b1}};
    end else begin
      sync1_r <= KEY_IN;
      sync2_r <= sync1_r;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [DCW-1:0] db_cnt_r, db_cnt_s;
    logic           level_r, level_s;
    logic           press_r, press_s;
    logic           release_r, release_s;
    logic           repeat_r, repeat_s;
    logic [RCW-1:0] rcnt_r, rcnt_s;
    rpt_state_t     state_r, state_s;

    // Debounce: a new level must be seen on DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
      db_cnt_s  = db_cnt_r;
      level_s   = level_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      if (sync2_r[k] == level_r) begin
        db_cnt_s = {DCW{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        db_cnt_s  = {DCW{1'b0}};
        level_s   = sync2_r[k];
        press_s   = ~sync2_r[k];
        release_s = sync2_r[k];
      end else begin
        db_cnt_s = db_cnt_r + DCW'(1'b1);
      end
    end

    // Repeat FSM next state; a release always wins over a REPEAT that is due.
    always_comb begin
      state_s  = state_r;
      rcnt_s   = rcnt_r;
      repeat_s = 1'b0;
      if (release_s) begin
        state_s = IDLE;
        rcnt_s  = {RCW{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            rcnt_s = {RCW{1'b0}};
            if (press_s) begin
              state_s = HOLD;
            end else begin
              state_s = IDLE;
            end
          end
          HOLD: begin
            if (!REPEAT_EN) begin
              rcnt_s = {RCW{1'b0}};
            end else if (rcnt_r == DELAY_LAST) begin
              repeat_s = 1'b1;
              state_s  = RPT;
              rcnt_s   = {RCW{1'b0}};
            end else begin
              rcnt_s = rcnt_r + RCW'(1'b1);
            end
          end
          RPT: begin
            if (!REPEAT_EN) begin
              state_s = HOLD;
              rcnt_s  = {RCW{1'b0}};
            end else if (rcnt_r == RATE_LAST) begin
              repeat_s = 1'b1;
              rcnt_s   = {RCW{1'b0}};
            end else begin
              rcnt_s = rcnt_r + RCW'(1'b1);
            end
          end
          default: begin
            state_s = IDLE;
            rcnt_s  = {RCW{1'b0}};
          end
        endcase
      end
    end

    // Per-key state and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
        db_cnt_r  <= {DCW{1'b0}};
        level_r   <= 1'b1;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
        rcnt_r    <= {RCW{1'b0}};
        state_r   <= IDLE;
      end else begin
        db_cnt_r  <= db_cnt_s;
        level_r   <= level_s;
        press_r   <= press_s;
        release_r <= release_s;
        repeat_r  <= repeat_s;
        rcnt_r    <= rcnt_s;
        state_r   <= state_s;
      end
    end

    assign KEY_LEVEL[k] = level_r;
    assign PRESS[k]     = press_r;
    assign RELEASE[k]   = release_r;
    assign REPEAT[k]    = repeat_r;
  end

endmodule
